dcache_controller: RTL and testbench

Sequencing FSM for the 16-set, 2-way, 256-bit-line data cache SRAM. It accepts CPU word load/store requests, resolves hits in the same cycle, and stalls the CPU on a miss. On a miss it writes back a dirty victim line, refills from main memory, and replays the access. It sits between the CPU memory stage, the dcache SRAM and the off-chip memory port.

---
 rtl/dcache_controller.sv | 189 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller
//  Description : Sequencing FSM for a 16-set, 2-way, 256-bit-line data cache.
//                Hits complete in the lookup cycle. A miss stalls the CPU,
//                writes back a dirty victim, refills the line from memory and
//                replays the access.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller #(
    parameter int MEM_ADDR_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // CPU memory stage
    input  logic                   cpu_req_i,
    input  logic                   cpu_write_i,
    input  logic [MEM_ADDR_W-1:0]  cpu_addr_i,
    input  logic [31:0]            cpu_data_i,
    output logic [31:0]            cpu_data_o,
    output logic                   cpu_stall_o,
    // Cache SRAM
    output logic                   sram_enable_o,
    output logic                   sram_write_o,
    output logic [3:0]             sram_addr_o,
    output logic [MEM_ADDR_W-8:0]  sram_tag_o,
    output logic [255:0]           sram_data_o,
    input  logic                   sram_hit_i,
    input  logic [MEM_ADDR_W-8:0]  sram_tag_i,
    input  logic [255:0]           sram_data_i,
    // Off-chip memory port
    output logic                   mem_enable_o,
    output logic                   mem_write_o,
    output logic [MEM_ADDR_W-1:0]  mem_addr_o,
    output logic [255:0]           mem_data_o,
    input  logic [255:0]           mem_data_i,
    input  logic                   mem_ack_i
);

    // Tag field width: everything above offset [4:0] and index [8:5].
    localparam int c_TAG_W = MEM_ADDR_W - 9;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MISS       = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_READMISS   = 3'd3,
        S_READMISSOK = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    mem_enable_q, mem_enable_d;
    logic                    mem_write_q, mem_write_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [255:0]            mem_data_q, mem_data_d;
    logic [255:0]            refill_q, refill_d;

    logic [c_TAG_W-1:0]      w_tag;
    logic [3:0]              w_index;
    logic [7:0]              w_bit_base;
    logic [255:0]            w_merged;
    logic                    w_victim_dirty;
    logic                    w_ack;
    logic                    w_lsb_unused;

    assign w_tag          = cpu_addr_i[MEM_ADDR_W-1:9];
    assign w_index        = cpu_addr_i[8:5];
    assign w_bit_base     = {cpu_addr_i[4:2], 5'b00000};
    assign w_victim_dirty = sram_tag_i[c_TAG_W+1] & sram_tag_i[c_TAG_W];
    // A completion pulse only counts while a memory request is outstanding.
    assign w_ack          = mem_ack_i & mem_enable_q;
    assign w_lsb_unused   = ^cpu_addr_i[1:0];

    assign sram_addr_o  = w_index;
    assign cpu_data_o   = sram_data_i[w_bit_base +: 32];
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // Store merge: the looked-up line with the addressed word replaced.
    always_comb begin
        w_merged                  = sram_data_i;
        w_merged[w_bit_base +: 32] = cpu_data_i;
    end

    // State and memory-port registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            refill_q     <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            refill_q     <= refill_d;
        end
    end

    // Next-state, memory-request sequencing and SRAM/CPU strobes.
    always_comb begin
        state_d       = state_q;
        mem_enable_d  = mem_enable_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        refill_d      = refill_q;
        cpu_stall_o   = 1'b0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_tag_o    = {2'b00, w_tag};
        sram_data_o   = w_merged;

        case (state_q)
            S_IDLE: begin
                sram_enable_o = cpu_req_i;
                if (cpu_req_i) begin
                    if (sram_hit_i) begin
                        if (cpu_write_i) begin
                            sram_write_o = 1'b1;
                            sram_tag_o   = {2'b11, w_tag};
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = S_MISS;
                    end
                end
            end

            // The SRAM presents the LRU victim here; decide on writeback.
            S_MISS: begin
                cpu_stall_o   = 1'b1;
                sram_enable_o = 1'b1;
                mem_enable_d  = 1'b1;
                if (w_victim_dirty) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = {sram_tag_i[c_TAG_W-1:0], w_index, 5'b00000};
                    mem_data_d  = sram_data_i;
                    state_d     = S_WRITEBACK;
                end else begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = {cpu_addr_i[MEM_ADDR_W-1:5], 5'b00000};
                    state_d     = S_READMISS;
                end
            end

            // Request stays asserted across the switch to the refill read.
            S_WRITEBACK: begin
                cpu_stall_o = 1'b1;
                if (w_ack) begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = {cpu_addr_i[MEM_ADDR_W-1:5], 5'b00000};
                    state_d     = S_READMISS;
                end
            end

            S_READMISS: begin
                cpu_stall_o = 1'b1;
                if (w_ack) begin
                    refill_d     = mem_data_i;
                    mem_enable_d = 1'b0;
                    state_d      = S_READMISSOK;
                end
            end

            // Install the refilled line as valid and clean into the LRU way.
            S_READMISSOK: begin
                cpu_stall_o   = 1'b1;
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_data_o   = refill_q;
                sram_tag_o    = {2'b10, w_tag};
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_controller
//  Description : Directed self-checking bench for dcache_controller: a table
//                of single-cycle hit/idle vectors plus scripted miss,
//                writeback, long-latency and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic         clk;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_hit_i;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks;
    int failures;

    dcache_controller #(.MEM_ADDR_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_write_i   (cpu_write_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_stall_o   (cpu_stall_o),
        .sram_enable_o (sram_enable_o),
        .sram_write_o  (sram_write_o),
        .sram_addr_o   (sram_addr_o),
        .sram_tag_o    (sram_tag_o),
        .sram_data_o   (sram_data_o),
        .sram_hit_i    (sram_hit_i),
        .sram_tag_i    (sram_tag_i),
        .sram_data_i   (sram_data_i),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lines used as SRAM / memory contents (word 0 is the rightmost).
    localparam logic [255:0] LINE_T = 256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000;
    localparam logic [255:0] LINE_A = 256'h77777777_66666666_55555555_44444444_33333333_22222222_DEADBEEF_00000000;
    localparam logic [255:0] LINE_C = 256'h77777777_66666666_55555555_44444444_33333333_22222222_CAFEF00D_00000000;
    localparam logic [255:0] LINE_B = 256'hB0000007_B0000006_B0000005_B0000004_B0000003_B0000002_B0000001_B0000000;
    localparam logic [255:0] LINE_D = 256'hD0000007_D0000006_D0000005_D0000004_D0000003_D0000002_D0000001_D0000000;
    localparam logic [255:0] LINE_E = 256'hE0000007_E0000006_E0000005_E0000004_E0000003_E0000002_E0000001_E0000000;

    typedef struct {
        string        name;
        logic         req;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         hit;
        logic [255:0] sdata;
        logic [31:0]  exp_rdata;
        logic         exp_stall;
        logic         exp_swr;
        logic         exp_sen;
        logic [3:0]   exp_idx;
        logic [255:0] exp_sdata;
        logic [24:0]  exp_stag;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Walks one miss from the MISS cycle to the replay cycle in IDLE.
    // The caller has already observed cycle 0 (miss detected, stall high).
    task automatic do_miss(input int wb_lat, input int rd_lat, input logic [255:0] refill,
                           input logic [31:0] wb_addr, input logic [255:0] wb_data,
                           input logic [31:0] rd_addr, output int n);
        n = 1;
        @(negedge clk); #1;
        if (cpu_stall_o) n++;
        chk("miss_en_low", mem_enable_o, 1'b0);
        for (int k = 1; k <= wb_lat; k++) begin
            @(negedge clk); #1;
            if (cpu_stall_o) n++;
            chk("wb_en", mem_enable_o, 1'b1);
            chk("wb_write", mem_write_o, 1'b1);
            if (k == 1) begin
                chk("wb_addr", mem_addr_o, wb_addr);
                chk("wb_data", mem_data_o, wb_data);
            end
            mem_ack_i = (k == wb_lat);
        end
        for (int k = 1; k <= rd_lat; k++) begin
            @(negedge clk); #1;
            mem_ack_i = 1'b0;
            if (cpu_stall_o) n++;
            chk("rd_en", mem_enable_o, 1'b1);
            chk("rd_write", mem_write_o, 1'b0);
            if (k == 1) chk("rd_addr", mem_addr_o, rd_addr);
            if (k == rd_lat) begin
                mem_data_i = refill;
                mem_ack_i  = 1'b1;
            end
        end
        @(negedge clk); #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '1;
        if (cpu_stall_o) n++;
        chk("ok_en_low", mem_enable_o, 1'b0);
        chk("ok_swr", sram_write_o, 1'b1);
        chk("ok_sen", sram_enable_o, 1'b1);
        chk("ok_sdata", sram_data_o, refill);
        chk("ok_vd", sram_tag_o[24:23], 2'b10);
        @(negedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i  = '0;
        cpu_data_i  = '0;
        sram_hit_i  = 1'b0;
        sram_tag_i  = '0;
        sram_data_i = '0;
        mem_data_i  = '0;
        mem_ack_i   = 1'b0;

        vecs[0] = '{name:"ld_w1", req:1'b1, wr:1'b0, addr:32'h0000_0104, wdata:32'h0, hit:1'b1, sdata:LINE_T,
                    exp_rdata:32'hA0000001, exp_stall:1'b0, exp_swr:1'b0, exp_sen:1'b1, exp_idx:4'd8,
                    exp_sdata:'0, exp_stag:'0};
        vecs[1] = '{name:"ld_w7", req:1'b1, wr:1'b0, addr:32'h0000_03FC, wdata:32'h0, hit:1'b1, sdata:LINE_T,
                    exp_rdata:32'hA0000007, exp_stall:1'b0, exp_swr:1'b0, exp_sen:1'b1, exp_idx:4'd15,
                    exp_sdata:'0, exp_stag:'0};
        vecs[2] = '{name:"ld_w0", req:1'b1, wr:1'b0, addr:32'h0000_0000, wdata:32'h0, hit:1'b1, sdata:LINE_T,
                    exp_rdata:32'hA0000000, exp_stall:1'b0, exp_swr:1'b0, exp_sen:1'b1, exp_idx:4'd0,
                    exp_sdata:'0, exp_stag:'0};
        vecs[3] = '{name:"st_w2", req:1'b1, wr:1'b1, addr:32'hABCD_E108, wdata:32'h12345678, hit:1'b1, sdata:LINE_T,
                    exp_rdata:32'h0, exp_stall:1'b0, exp_swr:1'b1, exp_sen:1'b1, exp_idx:4'd8,
                    exp_sdata:256'hA0000007_A0000006_A0000005_A0000004_A0000003_12345678_A0000001_A0000000,
                    exp_stag:25'h1D5E6F0};
        vecs[4] = '{name:"st_w7", req:1'b1, wr:1'b1, addr:32'h0000_01FC, wdata:32'hFFFFFFFF, hit:1'b1, sdata:LINE_T,
                    exp_rdata:32'h0, exp_stall:1'b0, exp_swr:1'b1, exp_sen:1'b1, exp_idx:4'd15,
                    exp_sdata:256'hFFFFFFFF_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000,
                    exp_stag:25'h1800000};
        vecs[5] = '{name:"no_req", req:1'b0, wr:1'b1, addr:32'h0000_0000, wdata:32'h5555AAAA, hit:1'b0, sdata:LINE_T,
                    exp_rdata:32'h0, exp_stall:1'b0, exp_swr:1'b0, exp_sen:1'b0, exp_idx:4'd0,
                    exp_sdata:'0, exp_stag:'0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_en", mem_enable_o, 1'b0);
        chk("rst_mem_wr", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 256'h0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;

        // Single-cycle IDLE behaviour
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_req_i   = vecs[i].req;
            cpu_write_i = vecs[i].wr;
            cpu_addr_i  = vecs[i].addr;
            cpu_data_i  = vecs[i].wdata;
            sram_hit_i  = vecs[i].hit;
            sram_data_i = vecs[i].sdata;
            #1;
            chk({vecs[i].name, "_stall"}, cpu_stall_o, vecs[i].exp_stall);
            chk({vecs[i].name, "_swr"}, sram_write_o, vecs[i].exp_swr);
            chk({vecs[i].name, "_sen"}, sram_enable_o, vecs[i].exp_sen);
            chk({vecs[i].name, "_idx"}, sram_addr_o, vecs[i].exp_idx);
            if (vecs[i].req && !vecs[i].wr) chk({vecs[i].name, "_rdata"}, cpu_data_o, vecs[i].exp_rdata);
            if (vecs[i].exp_swr) begin
                chk({vecs[i].name, "_sdata"}, sram_data_o, vecs[i].exp_sdata);
                chk({vecs[i].name, "_stag"}, sram_tag_o, vecs[i].exp_stag);
            end
        end

        // Cold load miss, refill latency 4
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0104;
        sram_hit_i = 1'b0; sram_tag_i = 25'h0; sram_data_i = '0;
        #1;
        chk("A_stall0", cpu_stall_o, 1'b1);
        do_miss(0, 4, LINE_A, 32'h0, 256'h0, 32'h0000_0100, n);
        chk("A_stall_cycles", n, 7);
        sram_hit_i = 1'b1; sram_data_i = LINE_A;
        #1;
        chk("A_replay_stall", cpu_stall_o, 1'b0);
        chk("A_replay_data", cpu_data_o, 32'hDEADBEEF);

        // Repeat load hits with no memory traffic
        @(negedge clk); #1;
        chk("B_stall", cpu_stall_o, 1'b0);
        chk("B_data", cpu_data_o, 32'hDEADBEEF);
        chk("B_mem_en", mem_enable_o, 1'b0);

        // Store hit marks the line dirty, then reload
        @(negedge clk);
        cpu_write_i = 1'b1; cpu_data_i = 32'hCAFEF00D;
        #1;
        chk("C_swr", sram_write_o, 1'b1);
        chk("C_stag", sram_tag_o, 25'h1800000);
        chk("C_sdata", sram_data_o, LINE_C);
        chk("C_stall", cpu_stall_o, 1'b0);
        @(negedge clk);
        cpu_write_i = 1'b0; sram_data_i = LINE_C;
        #1;
        chk("C_reload", cpu_data_o, 32'hCAFEF00D);

        // Second tag in set 8 fills the invalid way
        @(negedge clk);
        cpu_addr_i = 32'h0000_2104; sram_hit_i = 1'b0; sram_tag_i = 25'h0; sram_data_i = '0;
        #1;
        chk("D1_stall0", cpu_stall_o, 1'b1);
        do_miss(0, 2, LINE_B, 32'h0, 256'h0, 32'h0000_2100, n);
        chk("D1_stall_cycles", n, 5);
        sram_hit_i = 1'b1; sram_data_i = LINE_B;
        #1;
        chk("D1_data", cpu_data_o, 32'hB0000001);

        // Third tag evicts the dirty 0x100 line
        @(negedge clk);
        cpu_addr_i = 32'h0000_4104; sram_hit_i = 1'b0; sram_tag_i = 25'h1800000; sram_data_i = LINE_C;
        #1;
        chk("D2_stall0", cpu_stall_o, 1'b1);
        do_miss(3, 2, LINE_D, 32'h0000_0100, LINE_C, 32'h0000_4100, n);
        chk("D2_stall_cycles", n, 8);
        sram_hit_i = 1'b1; sram_data_i = LINE_D;
        #1;
        chk("D2_data", cpu_data_o, 32'hD0000001);
        chk("D2_stall", cpu_stall_o, 1'b0);

        // Stray ack in IDLE, then a 20-cycle refill
        @(negedge clk);
        cpu_req_i = 1'b0; sram_hit_i = 1'b0; mem_ack_i = 1'b1;
        #1;
        chk("E_idle_ack_stall", cpu_stall_o, 1'b0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        chk("E_idle_ack_en", mem_enable_o, 1'b0);
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_addr_i = 32'h8000_0040; sram_tag_i = 25'h1001234; sram_data_i = LINE_T;
        #1;
        chk("E_stall0", cpu_stall_o, 1'b1);
        do_miss(0, 20, LINE_E, 32'h0, 256'h0, 32'h8000_0040, n);
        chk("E_stall_cycles", n, 23);
        sram_hit_i = 1'b1; sram_data_i = LINE_E;
        #1;
        chk("E_data", cpu_data_o, 32'hE0000000);
        @(negedge clk);
        mem_ack_i = 1'b1;
        #1;
        chk("E_hit_ack_stall", cpu_stall_o, 1'b0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        chk("E_hit_ack_en", mem_enable_o, 1'b0);

        // Reset pulsed while waiting for the refill
        @(negedge clk);
        cpu_addr_i = 32'h0000_0104; sram_hit_i = 1'b0; sram_tag_i = 25'h0; sram_data_i = '0;
        #1;
        chk("F_stall0", cpu_stall_o, 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        chk("F_en_before_rst", mem_enable_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("F_rst_en", mem_enable_o, 1'b0);
        chk("F_rst_wr", mem_write_o, 1'b0);
        chk("F_rst_addr", mem_addr_o, 32'h0);
        chk("F_rst_data", mem_data_o, 256'h0);
        cpu_req_i = 1'b0;
        #1;
        chk("F_rst_idle", cpu_stall_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0; cpu_req_i = 1'b1;
        #1;
        chk("F_re_stall0", cpu_stall_o, 1'b1);
        do_miss(0, 1, LINE_A, 32'h0, 256'h0, 32'h0000_0100, n);
        chk("F_stall_cycles", n, 4);
        sram_hit_i = 1'b1; sram_data_i = LINE_A;
        #1;
        chk("F_data", cpu_data_o, 32'hDEADBEEF);

        @(negedge clk);
        cpu_req_i = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
